// File: rtl/zap_data_wb_sequencer.sv
// zap_data_wb_sequencer: one Wishbone B3 classic data cycle per LD/ST, with stall, fault and read-data capture.
// Optional bus timeout enabled by defining ZAP_DWB_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module zap_data_wb_sequencer #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_req_cyc,
    input  logic        i_req_stb,
    input  logic        i_req_we,
    input  logic [31:0] i_req_adr,
    input  logic [31:0] i_req_dat,
    input  logic [3:0]  i_req_sel,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_dat,
    output logic        o_data_stall,
    output logic        o_data_mem_fault,
    output logic [31:0] o_rd_data,
    output logic        o_rd_valid
);
    typedef enum logic [1:0] {IDLE, BUS, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        fault_q, fault_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        req, clr, term, expired;

    assign req  = i_req_cyc & i_req_stb;
    assign clr  = i_clear_from_writeback;
    assign term = i_wb_ack | i_wb_err;

`ifdef ZAP_DWB_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    assign expired = ~term & (cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
    assign expired = 1'b0 && (TIMEOUT_CYCLES != 32'd0);
`endif

    // Next-state and next-output computation for the bus sequencer.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        sel_d      = sel_q;
        fault_d    = 1'b0;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`ifdef ZAP_DWB_TIMEOUT_EN
        cnt_d      = cnt_q + 32'd1;
`endif
        case (state_q)
            IDLE: begin
                if (req && !clr) begin
                    if (|i_req_sel) begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                        we_d    = i_req_we;
                        adr_d   = {i_req_adr[31:2], 2'b00};
                        dat_d   = i_req_dat;
                        sel_d   = i_req_sel;
`ifdef ZAP_DWB_TIMEOUT_EN
                        cnt_d   = 32'd0;
`endif
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUS: begin
                if (term || expired) begin
                    cyc_d      = 1'b0;
                    state_d    = clr ? IDLE : DONE;
                    fault_d    = ~clr & (i_wb_err | expired);
                    rd_valid_d = ~clr & ~i_wb_err & ~expired & ~we_q;
                    rd_data_d  = rd_valid_d ? i_wb_dat : rd_data_q;
                end else if (clr) begin
                    state_d = DRAIN;
`ifdef ZAP_DWB_TIMEOUT_EN
                    cnt_d   = 32'd0;
`endif
                end
            end
            DRAIN: begin
                if (term || expired) begin
                    cyc_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= 32'd0;
            dat_q      <= 32'd0;
            sel_q      <= 4'd0;
            fault_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
`ifdef ZAP_DWB_TIMEOUT_EN
            cnt_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            sel_q      <= sel_d;
            fault_q    <= fault_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`ifdef ZAP_DWB_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign o_wb_cyc         = cyc_q;
    assign o_wb_stb         = cyc_q;
    assign o_wb_we          = we_q;
    assign o_wb_adr         = adr_q;
    assign o_wb_dat         = dat_q;
    assign o_wb_sel         = sel_q;
    assign o_data_mem_fault = fault_q;
    assign o_rd_valid       = rd_valid_q;
    assign o_rd_data        = rd_data_q;
    assign o_data_stall     = ((state_q == IDLE) & req) | (state_q == BUS) | (state_q == DRAIN);
endmodule

// File: tb/tb_zap_data_wb_sequencer.sv
// tb_zap_data_wb_sequencer: directed scoreboard bench for the data Wishbone sequencer.
module tb_zap_data_wb_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        req_cyc = 1'b0, req_stb = 1'b0, req_we = 1'b0;
    logic [31:0] req_adr = '0, req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_ack = 1'b0, wb_err = 1'b0;
    logic [31:0] wb_dat_i = '0;
    logic        stall, fault, rd_valid;
    logic [31:0] rd_data;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] rd_exp[$];
    logic        flt_exp[$];

    zap_data_wb_sequencer #(.TIMEOUT_CYCLES(32'd4)) dut (
        .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr),
        .i_req_cyc(req_cyc), .i_req_stb(req_stb), .i_req_we(req_we),
        .i_req_adr(req_adr), .i_req_dat(req_dat), .i_req_sel(req_sel),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
        .o_wb_adr(wb_adr), .o_wb_dat(wb_dat_o), .o_wb_sel(wb_sel),
        .i_wb_ack(wb_ack), .i_wb_err(wb_err), .i_wb_dat(wb_dat_i),
        .o_data_stall(stall), .o_data_mem_fault(fault),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        req_cyc = 1'b1; req_stb = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    endtask

    task automatic drop_req();
        req_cyc = 1'b0; req_stb = 1'b0;
    endtask

    task automatic bus_state(input string tag, input logic exp_cyc);
        chk({tag, "_cyc"}, wb_cyc, exp_cyc);
        chk({tag, "_stb"}, wb_stb, exp_cyc);
        chk({tag, "_stall"}, stall, exp_cyc);
    endtask

    // A transient request stalls only in IDLE; DONE would leave stall low.
    task automatic probe_idle(input string tag);
        issue(1'b0, 32'h0, 32'h0, 4'hF);
        #1 chk({tag, "_idle_stall"}, stall, 1'b1);
        drop_req();
        #1;
    endtask

    // Scoreboard side: pop expected results whenever the DUT reports one.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            vectors++;
            assert (rd_exp.size() > 0 && rd_data === rd_exp[0]) else begin
                miscompares++;
                $error("FAIL sb_rd observed=0x%08h expected=0x%08h pending=%0d", rd_data,
                       rd_exp.size() > 0 ? rd_exp[0] : 32'hx, rd_exp.size());
            end
            if (rd_exp.size() > 0) void'(rd_exp.pop_front());
        end
        if (!rst && fault) begin
            vectors++;
            assert (flt_exp.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_fault observed=1 expected=0 (no fault pending)");
            end
            if (flt_exp.size() > 0) void'(flt_exp.pop_front());
        end
    end

    initial begin
        int low_cnt;
        step(); step();
        chk("rst_cyc", wb_cyc, 1'b0);
        chk("rst_we", wb_we, 1'b0);
        chk("rst_adr", wb_adr, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);
        chk("rst_sel", {28'h0, wb_sel}, 32'h0);
        chk("rst_fault", fault, 1'b0);
        chk("rst_rdv", rd_valid, 1'b0);
        chk("rst_rdd", rd_data, 32'h0);
        rst = 1'b0;

        step();
        probe_idle("ack_idle");
        wb_ack = 1'b1; wb_dat_i = 32'hCAFEF00D;
        step(); wb_ack = 1'b0;
        chk("ack_idle_cyc", wb_cyc, 1'b0);
        chk("ack_idle_rdv", rd_valid, 1'b0);

        // Load: req cycle 0, ack cycle 3, result cycle 4.
        step(); issue(1'b0, 32'h1003, 32'h0, 4'hF); rd_exp.push_back(32'hDEADBEEF);
        #1 chk("ld_c0_stall", stall, 1'b1);
        step(); drop_req();
        bus_state("ld_c1", 1'b1);
        chk("ld_c1_adr", wb_adr, 32'h1000);
        chk("ld_c1_we", wb_we, 1'b0);
        step(); bus_state("ld_c2", 1'b1);
        chk("ld_c2_adr", wb_adr, 32'h1000);
        step(); bus_state("ld_c3", 1'b1);
        chk("ld_c3_adr", wb_adr, 32'h1000);
        wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
        step(); wb_ack = 1'b0; wb_dat_i = 32'h0;
        bus_state("ld_c4", 1'b0);
        chk("ld_c4_rdv", rd_valid, 1'b1);
        chk("ld_c4_rdd", rd_data, 32'hDEADBEEF);
        chk("ld_c4_fault", fault, 1'b0);
        step();
        chk("ld_c5_rdv", rd_valid, 1'b0);
        probe_idle("ld_c5");

        // Store with minimum latency.
        step(); issue(1'b1, 32'h2000, 32'h12345678, 4'h3);
        step(); drop_req();
        bus_state("st_c1", 1'b1);
        chk("st_c1_we", wb_we, 1'b1);
        chk("st_c1_dat", wb_dat_o, 32'h12345678);
        chk("st_c1_sel", {28'h0, wb_sel}, 32'h3);
        wb_ack = 1'b1;
        step(); wb_ack = 1'b0;
        bus_state("st_c2", 1'b0);
        chk("st_c2_rdv", rd_valid, 1'b0);
        chk("st_c2_fault", fault, 1'b0);
        step(); probe_idle("st_c3");

        // Error wins over ack on a load.
        step(); issue(1'b0, 32'h3000, 32'h0, 4'hF); flt_exp.push_back(1'b1);
        step(); drop_req();
        bus_state("er_c1", 1'b1);
        wb_ack = 1'b1; wb_err = 1'b1; wb_dat_i = 32'h55555555;
        step(); wb_ack = 1'b0; wb_err = 1'b0;
        chk("er_c2_fault", fault, 1'b1);
        chk("er_c2_rdv", rd_valid, 1'b0);
        chk("er_c2_stall", stall, 1'b0);
        step();
        chk("er_c3_fault", fault, 1'b0);
        chk("er_rdd_kept", rd_data, 32'hDEADBEEF);

        // Flush during BUS drains until ack, then returns to IDLE silently.
        step(); issue(1'b0, 32'h4000, 32'h0, 4'hF);
        step(); drop_req();
        step(); bus_state("fl_c2", 1'b1); clr = 1'b1;
        step(); clr = 1'b0; bus_state("fl_c3", 1'b1);
        step(); bus_state("fl_c4", 1'b1);
        step(); bus_state("fl_c5", 1'b1);
        wb_ack = 1'b1; wb_dat_i = 32'h00000BAD;
        step(); wb_ack = 1'b0;
        bus_state("fl_c6", 1'b0);
        chk("fl_c6_fault", fault, 1'b0);
        chk("fl_c6_rdv", rd_valid, 1'b0);
        chk("fl_c6_rdd", rd_data, 32'hDEADBEEF);
        probe_idle("fl_c6");

        // Clear coinciding with ack discards the result.
        step(); issue(1'b0, 32'h4400, 32'h0, 4'hF);
        step(); drop_req(); wb_ack = 1'b1; wb_dat_i = 32'h11112222; clr = 1'b1;
        step(); wb_ack = 1'b0; clr = 1'b0;
        bus_state("clk_ack", 1'b0);
        chk("clk_ack_rdv", rd_valid, 1'b0);
        probe_idle("clk_ack");

        // sel==0 completes without a bus cycle.
        step(); issue(1'b0, 32'h5000, 32'h0, 4'h0);
        #1 chk("s0_c0_stall", stall, 1'b1);
        step(); drop_req();
        bus_state("s0_c1", 1'b0);
        chk("s0_c1_fault", fault, 1'b0);
        chk("s0_c1_rdv", rd_valid, 1'b0);
        step(); chk("s0_c2_cyc", wb_cyc, 1'b0);
        probe_idle("s0_c2");

        // Reset in BUS cycle 2 drops the bus at the next edge.
        step(); issue(1'b0, 32'h6000, 32'h0, 4'hF);
        step(); drop_req(); bus_state("rs_c1", 1'b1);
        step(); bus_state("rs_c2", 1'b1); rst = 1'b1;
        step(); rst = 1'b0;
        chk("rs_c3_cyc", wb_cyc, 1'b0);
        chk("rs_c3_stb", wb_stb, 1'b0);
        chk("rs_c3_adr", wb_adr, 32'h0);
        chk("rs_c3_rdd", rd_data, 32'h0);
        probe_idle("rs_c3");

        // Unacknowledged load: timeout fault if enabled, otherwise wait forever.
        step(); issue(1'b0, 32'h7000, 32'h0, 4'hF);
`ifdef ZAP_DWB_TIMEOUT_EN
        flt_exp.push_back(1'b1);
        step(); drop_req();
        step(); step();
        step(); bus_state("to_c4", 1'b1);
        step();
        bus_state("to_c5", 1'b0);
        chk("to_c5_fault", fault, 1'b1);
        chk("to_c5_rdv", rd_valid, 1'b0);
        step(); probe_idle("to_c6");
`else
        rd_exp.push_back(32'hA5A5A5A5);
        step(); drop_req();
        low_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!wb_cyc || !stall || fault) low_cnt++;
            step();
        end
        chk("nto_low_cycles", low_cnt, 0);
        bus_state("nto_c1001", 1'b1);
        wb_ack = 1'b1; wb_dat_i = 32'hA5A5A5A5;
        step(); wb_ack = 1'b0;
        chk("nto_rdv", rd_valid, 1'b1);
        chk("nto_rdd", rd_data, 32'hA5A5A5A5);
        step(); probe_idle("nto_end");
`endif

        step(); step();
        chk("sb_rd_left", rd_exp.size(), 0);
        chk("sb_flt_left", flt_exp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
